// File: rtl/sram_arbiter_if.sv
// Pipeline-side handshake bundle for sram_arbiter: IF fetch port and MEM data port.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output if_rdata, if_ack, dm_rdata, dm_ack
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the single async SRAM (Ram1) between IF fetch and MEM data ports, sequencing OE/WE/EN.
// Optional round-robin arbitration when SRAM_ARB_RR_EN is defined (default: fixed dm > if priority).
module sram_arbiter #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic              busy,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, ACK} state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_t;

  state_t            state_q, state_d;
  port_t             port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              busy_q, busy_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              en_n_q, en_n_d;
  logic              drive_q, drive_d;
  logic              dm_pick;

`ifdef SRAM_ARB_RR_EN
  port_t last_grant_q, last_grant_d;

  // The port not granted last wins a tie.
  always_comb begin
    dm_pick = bus.dm_req && (!bus.if_req || (last_grant_q == PORT_IF));
  end
`else
  always_comb begin
    dm_pick = bus.dm_req;
  end
`endif

  // Next-state, grant latching and registered pin decode.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.dm_req || bus.if_req) begin
          if (dm_pick) begin
            port_d  = PORT_DM;
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
          end else begin
            port_d  = PORT_IF;
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
          end
`ifdef SRAM_ARB_RR_EN
          last_grant_d = port_d;
`endif
          state_d = we_d ? WR_SETUP : RD;
        end
      end
      RD: begin
        if (port_q == PORT_DM) dm_rdata_d = Ram1Data;
        else                   if_rdata_d = Ram1Data;
        state_d = ACK;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = ACK;
      ACK:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    en_n_d   = (state_d == IDLE);
    oe_n_d   = (state_d != RD);
    we_n_d   = (state_d != WR_PULSE);
    drive_d  = we_d && ((state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == ACK));
    if_ack_d = (state_d == ACK) && (port_d == PORT_IF);
    dm_ack_d = (state_d == ACK) && (port_d == PORT_DM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      en_n_q     <= 1'b1;
      drive_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= PORT_IF;
`endif
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      busy_q     <= busy_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      en_n_q     <= en_n_d;
      drive_q    <= drive_d;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign busy         = busy_q;
  assign Ram1Addr     = addr_q;
  assign Ram1OE       = oe_n_q;
  assign Ram1WE       = we_n_q;
  assign Ram1EN       = en_n_q;
  assign Ram1Data     = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
